apb_bridge_nslv: RTL and testbench

Parametrised successor to the single-target host-to-APB bridge. It converts one host memory request (valid/ready, 32-bit address, byte strobes) into an APB3/APB4 transfer on one of NUM_SLV decoded slave ports. Host-visible errors come from the slave PSLVERR, from address-decode misses, and from an optional access timeout. It sits between the MCU host bus and the receiver's peripheral register blocks.

---
 rtl/apb_bridge_pkg.sv | 22 ++
 rtl/apb_addr_decode.sv | 23 ++
 rtl/apb_bridge_nslv.sv | 196 +++++++++++++++++++
 tb/tb_apb_bridge_nslv.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the multi-slave host-to-APB bridge.
// Holds the FSM state encoding, the host bus widths and the slave-index extraction.
package apb_bridge_pkg;

   localparam int HOST_AW = 32;
   localparam int DW      = 32;
   localparam int STRB_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   function automatic int unsigned slv_index(input logic [HOST_AW-1:0] addr,
                                              input int unsigned        slv_addr_w,
                                              input int unsigned        idx_w);
      return (addr >> slv_addr_w) & ((32'd1 << idx_w) - 32'd1);
   endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational window decode: hit when the tag above the slave index matches BASE_ADDR.
// Zero latency, no flow control; the bridge FSM samples hit/idx in IDLE.
module apb_addr_decode
   import apb_bridge_pkg::*;
#(
   parameter int          NUM_SLV    = 8,
   parameter int          SLV_ADDR_W = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   localparam int         IDX_W      = $clog2(NUM_SLV)
) (
   input  logic [HOST_AW-1:0] host_addr,
   output logic               hit,
   output logic [IDX_W-1:0]   idx
);

   localparam int TAG_LSB = SLV_ADDR_W + IDX_W;

   always_comb begin
      hit = (host_addr[HOST_AW-1:TAG_LSB] == BASE_ADDR[HOST_AW-1:TAG_LSB]);
      idx = IDX_W'(slv_index(host_addr, SLV_ADDR_W, IDX_W));
   end

endmodule

// File: rtl/apb_bridge_nslv.sv
// Host valid/ready to APB3/APB4 bridge over NUM_SLV decoded slaves; optional timeout via APB_BRIDGE_TIMEOUT_EN.
// host_ready at +3+waits after the sampling edge (+1 on decode miss); host waits by holding valid, slaves stall via pready.
module apb_bridge_nslv
   import apb_bridge_pkg::*;
#(
   parameter int          NUM_SLV     = 8,
   parameter int          SLV_ADDR_W  = 12,
   parameter int          PADDR_W     = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          TIMEOUT_CYC = 256
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  host_valid,
   output logic                  host_ready,
   input  logic [HOST_AW-1:0]    host_addr,
   input  logic [DW-1:0]         host_wdata,
   input  logic [STRB_W-1:0]     host_wstrb,
   output logic [DW-1:0]         host_rdata,
   output logic                  host_err,
   output logic [PADDR_W-1:0]    apb_paddr,
   output logic                  apb_pwrite,
   output logic [NUM_SLV-1:0]    apb_psel,
   output logic                  apb_penable,
   output logic [STRB_W-1:0]     apb_pstrb,
   output logic [DW-1:0]         apb_pwdata,
   input  logic [DW*NUM_SLV-1:0] apb_prdata,
   input  logic [NUM_SLV-1:0]    apb_pready,
   input  logic [NUM_SLV-1:0]    apb_pslverr
);

   localparam int IDX_W = $clog2(NUM_SLV);

   if (PADDR_W < SLV_ADDR_W + IDX_W || TIMEOUT_CYC < 2 || NUM_SLV < 2) begin : g_param_err
      $error("apb_bridge_nslv: illegal parameter combination");
   end

   state_e               state_q, state_d;
   logic                 host_ready_q, host_ready_d;
   logic                 host_err_q, host_err_d;
   logic [DW-1:0]        host_rdata_q, host_rdata_d;
   logic [PADDR_W-1:0]   paddr_q, paddr_d;
   logic                 pwrite_q, pwrite_d;
   logic [NUM_SLV-1:0]   psel_q, psel_d;
   logic                 penable_q, penable_d;
   logic [STRB_W-1:0]    pstrb_q, pstrb_d;
   logic [DW-1:0]        pwdata_q, pwdata_d;
   logic [IDX_W-1:0]     idx_q, idx_d;

   logic                 dec_hit;
   logic [IDX_W-1:0]     dec_idx;
   logic [NUM_SLV-1:0][DW-1:0] prdata_arr;
   logic                 sel_ready, sel_err, tmo_hit;

   apb_addr_decode #(
      .NUM_SLV    (NUM_SLV),
      .SLV_ADDR_W (SLV_ADDR_W),
      .BASE_ADDR  (BASE_ADDR)
   ) u_dec (
      .host_addr (host_addr),
      .hit       (dec_hit),
      .idx       (dec_idx)
   );

   // Only the addressed slave's handshake is observed; the others are don't-care.
   assign prdata_arr = apb_prdata;
   assign sel_ready  = apb_pready[idx_q];
   assign sel_err    = apb_pslverr[idx_q];

`ifdef APB_BRIDGE_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC);
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == SETUP) begin
         tmo_cnt_d = '0;
      end else if (state_q == ACCESS && !sel_ready) begin
         tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
   end

   // A ready on the limit cycle takes priority because ACCESS checks sel_ready first.
   assign tmo_hit = (state_q == ACCESS) && !sel_ready &&
                    (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge sys_clk) begin
      if (rst) tmo_cnt_q <= '0;
      else     tmo_cnt_q <= tmo_cnt_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      host_ready_d = 1'b0;
      host_err_d   = host_err_q;
      host_rdata_d = host_rdata_q;
      paddr_d      = paddr_q;
      pwrite_d     = pwrite_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      pstrb_d      = pstrb_q;
      pwdata_d     = pwdata_q;
      idx_d        = idx_q;
      case (state_q)
         IDLE: begin
            if (host_valid) begin
               if (dec_hit) begin
                  paddr_d         = host_addr[PADDR_W-1:0];
                  pwdata_d        = host_wdata;
                  pstrb_d         = host_wstrb;
                  pwrite_d        = |host_wstrb;
                  idx_d           = dec_idx;
                  psel_d          = '0;
                  psel_d[dec_idx] = 1'b1;
                  penable_d       = 1'b0;
                  state_d         = SETUP;
               end else begin
                  host_ready_d = 1'b1;
                  host_err_d   = 1'b1;
                  host_rdata_d = '0;
                  state_d      = RESP;
               end
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (sel_ready) begin
               host_rdata_d = pwrite_q ? '0 : prdata_arr[idx_q];
               host_err_d   = sel_err;
               host_ready_d = 1'b1;
               psel_d       = '0;
               penable_d    = 1'b0;
               state_d      = RESP;
            end else if (tmo_hit) begin
               host_rdata_d = '0;
               host_err_d   = 1'b1;
               host_ready_d = 1'b1;
               psel_d       = '0;
               penable_d    = 1'b0;
               state_d      = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q      <= IDLE;
         host_ready_q <= 1'b0;
         host_err_q   <= 1'b0;
         host_rdata_q <= '0;
         paddr_q      <= '0;
         pwrite_q     <= 1'b0;
         psel_q       <= '0;
         penable_q    <= 1'b0;
         pstrb_q      <= '0;
         pwdata_q     <= '0;
         idx_q        <= '0;
      end else begin
         state_q      <= state_d;
         host_ready_q <= host_ready_d;
         host_err_q   <= host_err_d;
         host_rdata_q <= host_rdata_d;
         paddr_q      <= paddr_d;
         pwrite_q     <= pwrite_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pstrb_q      <= pstrb_d;
         pwdata_q     <= pwdata_d;
         idx_q        <= idx_d;
      end
   end

   assign host_ready  = host_ready_q;
   assign host_err    = host_err_q;
   assign host_rdata  = host_rdata_q;
   assign apb_paddr   = paddr_q;
   assign apb_pwrite  = pwrite_q;
   assign apb_psel    = psel_q;
   assign apb_penable = penable_q;
   assign apb_pstrb   = pstrb_q;
   assign apb_pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_bridge_nslv.sv
// Randomised bench for apb_bridge_nslv: a per-transaction timeline model drives expectations
// that one negedge compare process checks every cycle; literal checks pin the directed cases.
module tb_apb_bridge_nslv;

   localparam int NS  = 8;
   localparam int TMO = 16;

   logic          sys_clk = 1'b0;
   logic          rst;
   logic          host_valid, host_ready, host_err;
   logic [31:0]   host_addr, host_wdata, host_rdata;
   logic [3:0]    host_wstrb;
   logic [15:0]   apb_paddr;
   logic          apb_pwrite, apb_penable;
   logic [NS-1:0] apb_psel, apb_pready, apb_pslverr;
   logic [3:0]    apb_pstrb;
   logic [31:0]   apb_pwdata;
   logic [32*NS-1:0] apb_prdata;

   apb_bridge_nslv #(.TIMEOUT_CYC(TMO)) dut (
      .sys_clk(sys_clk), .rst(rst),
      .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_wstrb(host_wstrb), .host_rdata(host_rdata),
      .host_err(host_err), .apb_paddr(apb_paddr), .apb_pwrite(apb_pwrite),
      .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pstrb(apb_pstrb),
      .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata), .apb_pready(apb_pready),
      .apb_pslverr(apb_pslverr)
   );

   always #5 sys_clk = ~sys_clk;

   int n_vec = 0;
   int n_err = 0;
   int n_setup = 0;
   bit chk_en = 1'b0;

   // Expected DUT outputs for the current cycle.
   logic [NS-1:0] e_psel;
   logic          e_penable, e_ready, e_err, e_pwrite;
   logic [31:0]   e_rdata, e_pwdata;
   logic [15:0]   e_paddr;
   logic [3:0]    e_pstrb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge sys_clk) begin
      if (chk_en) begin
         chk("psel",    32'(apb_psel),    32'(e_psel));
         chk("penable", 32'(apb_penable), 32'(e_penable));
         chk("ready",   32'(host_ready),  32'(e_ready));
         chk("rdata",   host_rdata,       e_rdata);
         chk("err",     32'(host_err),    32'(e_err));
         chk("paddr",   32'(apb_paddr),   32'(e_paddr));
         chk("pwrite",  32'(apb_pwrite),  32'(e_pwrite));
         chk("pstrb",   32'(apb_pstrb),   32'(e_pstrb));
         chk("pwdata",  apb_pwdata,       e_pwdata);
         if (apb_psel != '0 && !apb_penable) n_setup++;
      end
   end

   function automatic bit m_hit(input logic [31:0] a);
      return (a >> 15) == (32'h1000_0000 >> 15);
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a >> 12) % 8);
   endfunction

   task automatic drive_noise();
      apb_pready  = NS'($urandom);
      apb_pslverr = NS'($urandom);
      for (int k = 0; k < NS; k++) apb_prdata[k*32 +: 32] = $urandom;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sys_clk); #1;
         drive_noise();
      end
   endtask

   // One host request from an IDLE cycle; returns in the IDLE cycle after RESP.
   task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                       input int waits, input logic [31:0] rd, input logic serr,
                       input bit hold, input bit stall);
      bit hit;
      int idx;
      int len;
      hit = m_hit(addr);
      idx = m_idx(addr);
      len = hit ? 3 + waits : 1;
      host_valid = 1'b1; host_addr = addr; host_wdata = wdata; host_wstrb = strb;
      for (int c = 1; c <= len; c++) begin
         @(posedge sys_clk); #1;
         if (!hold) host_valid = 1'b0;
         if (c == 1 && hit) begin
            e_paddr = addr[15:0]; e_pwdata = wdata; e_pstrb = strb; e_pwrite = (strb != 4'h0);
         end
         e_ready   = (c == len);
         e_psel    = (hit && c < len) ? NS'(1 << idx) : '0;
         e_penable = hit && c >= 2 && c < len;
         if (c == len) begin
            e_err   = (!hit || stall) ? 1'b1 : serr;
            e_rdata = (hit && !stall && strb == 4'h0) ? rd : 32'h0;
         end
         drive_noise();
         if (hit && c >= 2 && c < len) begin
            apb_pready[idx]  = !stall && (c == len - 1);
            apb_pslverr[idx] = (c == len - 1) ? serr : 1'($urandom);
            apb_prdata[idx*32 +: 32] = rd;
         end
      end
      @(posedge sys_clk); #1;
      e_ready = 1'b0; e_psel = '0; e_penable = 1'b0;
      drive_noise();
   endtask

   // Read to a slave that never answers, then a one-cycle reset after ncyc cycles.
   task automatic stall_then_reset(input logic [31:0] addr, input int ncyc);
      int idx;
      idx = m_idx(addr);
      host_valid = 1'b1; host_addr = addr; host_wstrb = 4'h0; host_wdata = $urandom;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge sys_clk); #1;
         host_valid = 1'b0;
         if (c == 1) begin
            e_paddr = addr[15:0]; e_pwdata = host_wdata; e_pstrb = 4'h0; e_pwrite = 1'b0;
         end
         e_psel = NS'(1 << idx); e_penable = (c >= 2); e_ready = 1'b0;
         drive_noise();
         apb_pready[idx] = 1'b0;
      end
      rst = 1'b1;
      @(posedge sys_clk); #1;
      rst = 1'b0;
      e_psel = '0; e_penable = 1'b0; e_ready = 1'b0; e_err = 1'b0; e_rdata = '0;
      e_paddr = '0; e_pwdata = '0; e_pstrb = '0; e_pwrite = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst = 1'b1; host_valid = 1'b0; host_addr = '0; host_wdata = '0; host_wstrb = '0;
      apb_pready = '0; apb_pslverr = '0; apb_prdata = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      e_psel = '0; e_penable = 1'b0; e_ready = 1'b0; e_err = 1'b0; e_rdata = '0;
      e_paddr = '0; e_pwdata = '0; e_pstrb = '0; e_pwrite = 1'b0;
      chk_en = 1'b1;
      @(posedge sys_clk); #1;
      rst = 1'b0;
      idle(1);

      // Directed cases
      xfer(32'h1000_4000, 32'hAABB_CCDD, 4'hF, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("t1_pwdata", apb_pwdata, 32'hAABB_CCDD);
      chk("t1_pstrb", 32'(apb_pstrb), 32'hF);
      chk("t1_pwrite", 32'(apb_pwrite), 32'h1);
      xfer(32'h1000_5008, 32'h0, 4'h0, 2, 32'hCAFE_0005, 1'b0, 1'b0, 1'b0);
      chk("t2_rdata", host_rdata, 32'hCAFE_0005);
      chk("t2_paddr", 32'(apb_paddr), 32'h5008);
      xfer(32'h2000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("t3_err", 32'(host_err), 32'h1);
      chk("t3_rdata", host_rdata, 32'h0);
      xfer(32'h1000_0000, 32'h0, 4'h0, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      xfer(32'h1000_2000, 32'h5555_AAAA, 4'b0011, 0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("t4_pstrb", 32'(apb_pstrb), 32'h3);
      chk("t4_err", 32'(host_err), 32'h1);

      base = n_setup;
      for (int i = 0; i < 5; i++)
         xfer(32'h1000_0000 | (32'(i) << 12) | 32'h10, 32'h0, 4'h0, i % 3, $urandom, 1'b0, 1'b1, 1'b0);
      host_valid = 1'b0;
      idle(3);
      chk("b2b_count", 32'(n_setup - base), 32'd5);

`ifdef APB_BRIDGE_TIMEOUT_EN
      xfer(32'h1000_3000, 32'h0, 4'h0, TMO - 1, 32'h0, 1'b0, 1'b0, 1'b1);
      xfer(32'h1000_3004, 32'h0, 4'h0, TMO - 1, 32'hBEEF_0003, 1'b0, 1'b0, 1'b0);
      stall_then_reset(32'h1000_3000, 5);
`else
      stall_then_reset(32'h1000_3000, 1000);
`endif
      xfer(32'h1000_1004, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
      chk("t6_rdata", host_rdata, 32'h0BAD_F00D);
      stall_then_reset(32'h1000_6000, 3);
      idle(2);

      // Randomised traffic
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         logic [3:0]  s;
         if ($urandom_range(0, 5) == 0) begin
            a = $urandom;
            if (m_hit(a)) a = a ^ 32'h0010_0000;
         end else begin
            a = 32'h1000_0000 | (32'($urandom_range(0, 7)) << 12) | ($urandom & 32'hFFC);
         end
         s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         xfer(a, $urandom, s, $urandom_range(0, 4), $urandom,
              1'($urandom_range(0, 3) == 0), 1'($urandom), 1'b0);
         host_valid = 1'b0;
         idle($urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
